// File: rtl/bram_rd_arb.sv
// Round-robin read-port arbiter and response sequencer for a dual-port BRAM with a write pass-through.
// Optional same-cycle write-to-read forwarding is compiled in with `define BRAM_RD_ARB_FWD_EN.
module bram_rd_arb #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 2,
  localparam int unsigned ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          bram_ena,
  output logic                          bram_wea,
  output logic [ADDR_WIDTH-1:0]         bram_addra,
  output logic [DATA_WIDTH-1:0]         bram_dina,
  output logic                          bram_enb,
  output logic [ADDR_WIDTH-1:0]         bram_addrb,
  input  logic [DATA_WIDTH-1:0]         bram_doutb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data
);

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic                  can_issue;
  logic                  gnt_v;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic [ID_WIDTH-1:0]   last_grant;
  int unsigned           cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Write port is a straight pass-through; writes are never stalled.
  assign bram_ena   = wr_valid;
  assign bram_wea   = wr_valid;
  assign bram_addra = wr_addr;
  assign bram_dina  = wr_data;

  // The single response slot frees up when it is empty or being consumed this cycle.
  assign can_issue = !rsp_valid || rsp_ready;

  // Cyclic search starting just after the previous winner.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    cand   = 0;
    if (!rst && can_issue) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = 32'(last_grant) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!gnt_v && req_valid[ID_WIDTH'(cand)]) begin
          gnt_v  = 1'b1;
          gnt_id = ID_WIDTH'(cand);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_v) req_ready[gnt_id] = 1'b1;
  end

  // Port B is only enabled on a grant so the BRAM output register holds during backpressure.
  assign bram_enb   = gnt_v;
  assign bram_addrb = gnt_v ? addr_arr[gnt_id] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else if (gnt_v) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_id;
      last_grant <= gnt_id;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef BRAM_RD_ARB_FWD_EN
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  fwd_match;

  assign fwd_match = wr_valid && (wr_addr == bram_addrb);

  // Capture the write data when a granted read collides with a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else if (gnt_v) begin
      fwd_hit <= fwd_match;
      if (fwd_match) fwd_data <= wr_data;
    end
  end

  assign rsp_data = fwd_hit ? fwd_data : bram_doutb;
`else
  assign rsp_data = bram_doutb;
`endif

endmodule

// File: tb/tb_bram_rd_arb.sv
// Bench for bram_rd_arb: behavioural BRAM plus a transaction-level reference of the arbiter.
module tb_bram_rd_arb;
  localparam int DW = 512;
  localparam int AW = 8;
  localparam int NR = 2;
`ifdef BRAM_RD_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   req_ready;
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            bram_ena, bram_wea, bram_enb;
  logic [AW-1:0]   bram_addra, bram_addrb;
  logic [DW-1:0]   bram_dina, bram_doutb;
  logic            rsp_valid, rsp_ready;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  bram_rd_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM: port B samples the old word before the same-edge write lands.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (bram_ena && bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  // Reference state: memory contents, the pending response and the last winner.
  logic [DW-1:0] refmem [256];
  bit            e_valid;
  int            e_id;
  logic [DW-1:0] e_data;
  int            e_last;
  bit            e_gnt_v;
  int            e_gnt;
  logic [NR-1:0] e_ready;
  logic [AW-1:0] e_addrb;

  task automatic model_reset();
    e_valid = 0; e_id = 0; e_last = NR - 1; e_data = '0;
  endtask

  task automatic predict();
    e_gnt_v = 0; e_gnt = 0;
    if (!rst && (!e_valid || rsp_ready)) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (e_last + k) % NR;
        if (!e_gnt_v && req_valid[c]) begin e_gnt_v = 1; e_gnt = c; end
      end
    end
    e_ready = '0;
    if (e_gnt_v) e_ready[e_gnt] = 1'b1;
    e_addrb = req_addr[e_gnt*AW +: AW];
  endtask

  task automatic commit();
    if (e_gnt_v) begin
      e_valid = 1; e_id = e_gnt; e_last = e_gnt;
      e_data = (FWD && wr_valid && wr_addr == e_addrb) ? wr_data : refmem[e_addrb];
    end else if (rsp_ready) begin
      e_valid = 0;
    end
    if (wr_valid) refmem[wr_addr] = wr_data;
  endtask

  task automatic idle_cycle();
    req_valid = '0; wr_valid = 0; rsp_ready = 1;
    @(negedge clk); predict();
    @(posedge clk); commit(); #1;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 2'b11; req_addr = {8'h22, 8'h11}; rsp_ready = 1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid act=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id act=%0d exp=0", rsp_id); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready act=%b exp=00", req_ready); end
    n_cmp++; if (bram_enb !== 1'b0) begin n_err++; $display("FAIL reset_enb act=%b exp=0", bram_enb); end
    @(posedge clk); #1;
    rst = 0; req_valid = '0; model_reset();
  endtask

  task automatic test_alternate();
    logic [NR-1:0] er;
    req_valid = 2'b11; req_addr = {8'h20, 8'h10}; rsp_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); predict();
      er = (c % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (req_ready !== er) begin n_err++; $display("FAIL alt_grant c=%0d act=%b exp=%b", c, req_ready, er); end
      n_cmp++; if (bram_addrb !== ((c % 2 == 0) ? 8'h10 : 8'h20)) begin n_err++; $display("FAIL alt_addrb c=%0d act=%h", c, bram_addrb); end
      if (c > 0) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'((c - 1) % 2) || rsp_data !== DW'((c % 2 == 1) ? 'h10 : 'h20)) begin
          n_err++; $display("FAIL alt_rsp c=%0d act=%b/%0d/%h", c, rsp_valid, rsp_id, rsp_data[15:0]);
        end
      end
      @(posedge clk); commit(); #1;
    end
    req_valid = '0;
    @(negedge clk); predict();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== DW'('h20)) begin n_err++; $display("FAIL alt_last act=%b/%0d/%h exp=1/1/20", rsp_valid, rsp_id, rsp_data[15:0]); end
    @(posedge clk); commit(); #1;
    idle_cycle();
  endtask

  task automatic test_single_read();
    req_valid = 2'b01; req_addr = {8'h00, 8'h05}; rsp_ready = 1;
    @(negedge clk); predict();
    n_cmp++; if (req_ready !== 2'b01 || bram_enb !== 1'b1 || bram_addrb !== 8'h05) begin n_err++; $display("FAIL single_issue act=%b/%b/%h exp=01/1/05", req_ready, bram_enb, bram_addrb); end
    @(posedge clk); commit(); #1;
    req_valid = '0;
    @(negedge clk); predict();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid act=%b exp=1", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL single_id act=%0d exp=0", rsp_id); end
    n_cmp++; if (rsp_data !== DW'('h05)) begin n_err++; $display("FAIL single_data act=%h exp=05", rsp_data[15:0]); end
    @(posedge clk); commit(); #1;
  endtask

  task automatic test_backpressure();
    req_valid = 2'b01; req_addr = {8'h00, 8'h07}; rsp_ready = 1;
    @(negedge clk); predict();
    @(posedge clk); commit(); #1;
    rsp_ready = 0; req_valid = 2'b11; req_addr = {8'h12, 8'h11};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); predict();
      n_cmp++; if (req_ready !== 2'b00 || bram_enb !== 1'b0) begin n_err++; $display("FAIL bp_stall c=%0d act=%b/%b exp=00/0", c, req_ready, bram_enb); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== DW'('h07)) begin n_err++; $display("FAIL bp_hold c=%0d act=%b/%0d/%h exp=1/0/07", c, rsp_valid, rsp_id, rsp_data[15:0]); end
      @(posedge clk); commit(); #1;
    end
    rsp_ready = 1;
    @(negedge clk); predict();
    n_cmp++; if (req_ready !== 2'b10 || bram_enb !== 1'b1 || req_ready !== e_ready) begin n_err++; $display("FAIL bp_release act=%b/%b exp=10/1", req_ready, bram_enb); end
    @(posedge clk); commit(); #1;
    req_valid = '0;
    @(negedge clk); predict();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== DW'('h12)) begin n_err++; $display("FAIL bp_next act=%b/%0d/%h exp=1/1/12", rsp_valid, rsp_id, rsp_data[15:0]); end
    @(posedge clk); commit(); #1;
    idle_cycle();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] aa;
    aa = {64{8'hAA}};
    req_valid = '0; wr_valid = 1; wr_addr = 8'h33; wr_data = aa; rsp_ready = 1;
    @(negedge clk); predict();
    n_cmp++; if (bram_ena !== 1'b1 || bram_wea !== 1'b1 || bram_addra !== 8'h33 || bram_dina !== aa) begin n_err++; $display("FAIL wr_pass act=%b/%b/%h", bram_ena, bram_wea, bram_addra); end
    @(posedge clk); commit(); #1;
    wr_valid = 0; req_valid = 2'b01; req_addr = {8'h00, 8'h33};
    @(negedge clk); predict();
    n_cmp++; if (bram_ena !== 1'b0) begin n_err++; $display("FAIL wr_idle act=%b exp=0", bram_ena); end
    @(posedge clk); commit(); #1;
    req_valid = '0;
    @(negedge clk); predict();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== aa) begin n_err++; $display("FAIL wr_then_rd act=%b/%h exp=1/aa..", rsp_valid, rsp_data[15:0]); end
    @(posedge clk); commit(); #1;
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] bb;
    logic [DW-1:0] exp_d;
    bb = {64{8'hBB}};
    exp_d = FWD ? bb : DW'('h40);
    wr_valid = 1; wr_addr = 8'h40; wr_data = bb; req_valid = 2'b01; req_addr = {8'h00, 8'h40}; rsp_ready = 1;
    @(negedge clk); predict();
    @(posedge clk); commit(); #1;
    wr_valid = 0; req_valid = '0;
    @(negedge clk); predict();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_err++; $display("FAIL same_cycle act=%h exp=%h", rsp_data[15:0], exp_d[15:0]); end
    @(posedge clk); commit(); #1;
    req_valid = 2'b10; req_addr = {8'h40, 8'h00};
    @(negedge clk); predict();
    @(posedge clk); commit(); #1;
    req_valid = '0;
    @(negedge clk); predict();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== bb) begin n_err++; $display("FAIL same_cycle_after act=%h exp=bb..", rsp_data[15:0]); end
    @(posedge clk); commit(); #1;
  endtask

  task automatic test_reset_midread();
    req_valid = 2'b01; req_addr = {8'h00, 8'h09}; rsp_ready = 1; wr_valid = 0;
    @(negedge clk); predict();
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rmr_grant act=%b exp=01", req_ready); end
    @(posedge clk); commit(); #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rmr_inflight act=%b exp=1", rsp_valid); end
    rst = 1; req_valid = 2'b11; #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin n_err++; $display("FAIL rmr_async act=%b/%b exp=0/00", rsp_valid, req_ready); end
    @(posedge clk); #1;
    rst = 0; model_reset(); req_valid = '0;
    @(negedge clk); predict();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmr_no_rsp act=%b exp=0", rsp_valid); end
    @(posedge clk); commit(); #1;
    req_valid = 2'b11; req_addr = {8'h20, 8'h10};
    @(negedge clk); predict();
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rmr_first act=%b exp=01", req_ready); end
    @(posedge clk); commit(); #1;
    req_valid = '0;
    @(negedge clk); predict();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== DW'('h10)) begin n_err++; $display("FAIL rmr_rsp act=%b/%0d/%h exp=1/0/10", rsp_valid, rsp_id, rsp_data[15:0]); end
    @(posedge clk); commit(); #1;
  endtask

  task automatic test_random();
    logic [DW-1:0] wd;
    for (int c = 0; c < 400; c++) begin
      req_valid = NR'($urandom_range(0, 3));
      req_addr  = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
      rsp_ready = ($urandom_range(0, 3) != 0);
      wr_valid  = 1'($urandom_range(0, 1));
      wr_addr   = 8'($urandom_range(0, 15));
      for (int j = 0; j < DW / 32; j++) wd[j*32 +: 32] = $urandom;
      wr_data = wd;
      @(negedge clk); predict();
      n_cmp++; if (req_ready !== e_ready || bram_enb !== e_gnt_v) begin n_err++; $display("FAIL rnd_grant c=%0d act=%b/%b exp=%b/%b", c, req_ready, bram_enb, e_ready, e_gnt_v); end
      if (e_gnt_v) begin
        n_cmp++; if (bram_addrb !== e_addrb) begin n_err++; $display("FAIL rnd_addrb c=%0d act=%h exp=%h", c, bram_addrb, e_addrb); end
      end
      n_cmp++; if (rsp_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid c=%0d act=%b exp=%b", c, rsp_valid, e_valid); end
      if (e_valid) begin
        n_cmp++; if (rsp_id !== 1'(e_id) || rsp_data !== e_data) begin n_err++; $display("FAIL rnd_rsp c=%0d act=%0d/%h exp=%0d/%h", c, rsp_id, rsp_data[31:0], e_id, e_data[31:0]); end
      end
      @(posedge clk); commit(); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; req_valid = '0; req_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0; rsp_ready = 1;
    for (int k = 0; k < 256; k++) begin
      mem[k] = DW'(k);
      refmem[k] = DW'(k);
    end
    model_reset();
    test_reset();
    test_alternate();
    test_single_read();
    test_backpressure();
    test_write_read();
    test_same_cycle();
    test_reset_midread();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bram_rd_arb.md
# bram_rd_arb

Read-port arbiter and sequencer for the 256x512 dual-port block RAM in the VPS prototype memory path. Shares the single BRAM read port among NUM_REQ requesters using round-robin arbitration, tracks the one-cycle BRAM read latency, and returns data with a valid/ready response handshake. It also passes one write stream straight to the BRAM write port, with optional same-address write-to-read forwarding.

## Interface
- DATA_WIDTH, 512: BRAM word width.
- ADDR_WIDTH, 8: BRAM address width (256 entries).
- NUM_REQ, 2: read requesters, 2..8; ID_WIDTH = max(1, $clog2(NUM_REQ)).

- clk  in  1  single clock for the block and the BRAM (clka = clkb = clk).
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] && req_ready[i].
- wr_valid  in  1  write request; always accepted, no ready signal.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- bram_ena, bram_wea  out  1  BRAM port A enable and write enable.
- bram_addra  out  ADDR_WIDTH; bram_dina  out  DATA_WIDTH.
- bram_enb  out  1; bram_addrb  out  ADDR_WIDTH  BRAM port B read controls.
- bram_doutb  in  DATA_WIDTH  BRAM read data, registered in the BRAM, valid 1 cycle after bram_enb.
- rsp_valid  out  1; rsp_ready  in  1  response handshake.
- rsp_id  out  ID_WIDTH  index of the requester that owns rsp_data.
- rsp_data  out  DATA_WIDTH  read data.

## Operation
- Write path is combinational pass-through: bram_ena = bram_wea = wr_valid, bram_addra = wr_addr, bram_dina = wr_data.
- The response stage is one entry deep, held in the BRAM output register plus rsp_valid and rsp_id flops.
- can_issue = !rsp_valid || rsp_ready.
- Arbitration:
  - Only when can_issue is high: grant the first i with req_valid[i], searching cyclically from last_grant+1.
  - req_ready is one-hot or zero, and is never asserted when can_issue is low.
  - On a grant: bram_enb = 1, bram_addrb = granted address; last_grant <= i; next cycle rsp_valid <= 1, rsp_id <= i.
- No grant this cycle and the response is consumed: rsp_valid <= 0.
- bram_enb is 0 whenever there is no grant, so bram_doutb holds and rsp_data stays stable while rsp_valid && !rsp_ready.
- rsp_data = bram_doutb, except when it is forwarded (see Configuration).
- req_ready depends on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.

## Timing
- Reset values:
  - rsp_valid = 0, rsp_id = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - fwd_hit = 0, fwd_data = 0.
  - Combinational outputs follow their inputs; req_ready = 0 while in reset.
- Read latency: accept in cycle N; rsp_valid and rsp_data in cycle N+1.
- Throughput: 1 read per cycle when rsp_ready is held high.
- Backpressure: while rsp_valid && !rsp_ready, no grants are made and rsp_valid, rsp_id and rsp_data hold.
- Simultaneous consume and grant in the same cycle: rsp_valid stays 1 and the new data appears next cycle (no bubble).
- Read and write to the same address in the same cycle: the BRAM returns old data (read-first), unless forwarding is compiled in.
- Reset asserted mid-read: rsp_valid drops immediately and the in-flight read is discarded; the stale BRAM output is ignored.
- last_grant wraps from NUM_REQ-1 to 0.

## Configuration
- BRAM_RD_ARB_FWD_EN defined:
  - On a grant with wr_valid && wr_addr == granted address, register fwd_hit <= 1 and fwd_data <= wr_data.
  - On any other grant, fwd_hit <= 0.
  - fwd_hit and fwd_data hold while there is no grant.
  - rsp_data = fwd_hit ? fwd_data : bram_doutb, giving write-first semantics.
- Not defined: no forwarding registers exist, and rsp_data = bram_doutb (read-first).

## Test plan
- Memory preloaded with mem[k] = k. Requester 0 reads 0x05 with rsp_ready = 1 -> one cycle later rsp_valid = 1, rsp_id = 0, rsp_data = 0x05.
- Both requesters valid continuously, addresses 0x10 and 0x20, rsp_ready = 1 -> grants alternate 0,1,0,1 starting with 0, one response per cycle.
- Response pending with rsp_ready = 0 for 5 cycles -> req_ready = 0, bram_enb = 0, rsp_data stable. Then raise rsp_ready -> the next grant occurs in that same cycle.
- Write 0xAA..AA to 0x33, then read 0x33 in a later cycle -> rsp_data = 0xAA..AA.
- Write 0xBB..BB and read address 0x40 in the same cycle (old value 0x40):
  - With BRAM_RD_ARB_FWD_EN -> rsp_data = 0xBB..BB.
  - Without it -> rsp_data = 0x40.
- Assert rst during a cycle with a read in flight -> rsp_valid = 0 immediately and no response emerges. After release, requester 0 wins the first grant.
